// File: rtl/time_display_scan_57.sv
// HH-MM-SS multiplexer for an 8-digit common-anode 7-segment display. Optional macro DISPLAY_BLINK_EN blinks the field under correction.
// Latency: seg_57/dig_57 are registered and change 1 cycle after each scan tick. Inputs are snapshotted once per frame.
// Backpressure: none. The block free-runs and ignores mid-frame input changes until the next frame wrap.
module time_display_scan_57 #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk_50m_57,
    input  logic       rst_57,
    input  logic [6:0] sec_57,
    input  logic [6:0] min_57,
    input  logic [6:0] hour_57,
    input  logic [2:0] select_57,
    input  logic       correct_e_57,
    output logic [7:0] seg_57,
    output logic [7:0] dig_57
);
    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    logic [PW-1:0] psc;
    logic          tick;
    logic [2:0]    idx;

    logic [6:0] snap_sec, snap_min, snap_hour;
    logic [2:0] snap_sel;
    logic       snap_ce;

    logic [7:0] next_seg;

    function automatic logic [3:0] tens_of(input logic [6:0] v);
        if (v >= 7'd90)      return 4'd9;
        else if (v >= 7'd80) return 4'd8;
        else if (v >= 7'd70) return 4'd7;
        else if (v >= 7'd60) return 4'd6;
        else if (v >= 7'd50) return 4'd5;
        else if (v >= 7'd40) return 4'd4;
        else if (v >= 7'd30) return 4'd3;
        else if (v >= 7'd20) return 4'd2;
        else if (v >= 7'd10) return 4'd1;
        else                 return 4'd0;
    endfunction

    function automatic logic [3:0] units_of(input logic [6:0] v);
        logic [6:0] u;
        u = v - (7'(tens_of(v)) * 7'd10);
        return u[3:0];
    endfunction

    function automatic logic [7:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return SEG_BLANK;
        endcase
    endfunction

    assign tick = (psc == PW'(SCAN_DIV - 1));

    always_ff @(posedge clk_50m_57 or posedge rst_57) begin
        if (rst_57) begin
            psc <= '0;
            idx <= '0;
        end else if (tick) begin
            psc <= '0;
            idx <= idx + 3'd1;
        end else begin
            psc <= psc + PW'(1);
        end
    end

    // idx points at the digit the next tick drives, so the 7->0 wrap and the
    // snapshot share one edge and digit 0 always sees the fresh frame.
    always_ff @(posedge clk_50m_57 or posedge rst_57) begin
        if (rst_57) begin
            snap_sec  <= '0;
            snap_min  <= '0;
            snap_hour <= '0;
            snap_sel  <= '0;
            snap_ce   <= 1'b0;
        end else if (tick && idx == 3'd7) begin
            snap_sec  <= sec_57;
            snap_min  <= min_57;
            snap_hour <= hour_57;
            snap_sel  <= select_57;
            snap_ce   <= correct_e_57;
        end
    end

`ifdef DISPLAY_BLINK_EN
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    logic [BW-1:0] blink_cnt;
    logic          phase;

    always_ff @(posedge clk_50m_57 or posedge rst_57) begin
        if (rst_57) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (!snap_ce) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end
`endif

    always_comb begin
        logic [6:0] val;
        logic       bad;
        logic [2:0] mask;
        logic       is_dash;
        logic       is_units;
        logic       sel_hit;
        logic [7:0] digit_seg;

        val      = snap_sec;
        bad      = 1'b0;
        mask     = 3'b000;
        is_dash  = 1'b0;
        is_units = idx[0] ^ (idx >= 3'd3) ^ (idx >= 3'd6);
        case (idx)
            3'd0, 3'd1: begin val = snap_hour; bad = (snap_hour > 7'd23); mask = 3'b100; end
            3'd3, 3'd4: begin val = snap_min;  bad = (snap_min  > 7'd59); mask = 3'b010; end
            3'd6, 3'd7: begin val = snap_sec;  bad = (snap_sec  > 7'd59); mask = 3'b001; end
            default:    is_dash = 1'b1;
        endcase

        if (is_dash || bad)
            digit_seg = SEG_DASH;
        else if (is_units)
            digit_seg = enc(units_of(val));
        else
            digit_seg = enc(tens_of(val));

        sel_hit = snap_ce && !is_dash && (snap_sel == mask) &&
                  (snap_sel == 3'b001 || snap_sel == 3'b010 || snap_sel == 3'b100);

`ifdef DISPLAY_BLINK_EN
        next_seg = (sel_hit && phase) ? SEG_BLANK : digit_seg;
`else
        next_seg = (sel_hit && is_units) ? (digit_seg & 8'h7F) : digit_seg;
`endif
    end

    always_ff @(posedge clk_50m_57 or posedge rst_57) begin
        if (rst_57) begin
            seg_57 <= SEG_BLANK;
            dig_57 <= 8'hFF;
        end else if (tick) begin
            seg_57 <= next_seg;
            dig_57 <= ~(8'd1 << idx);
        end
    end

endmodule
